// File: rtl/mc_controller_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, funct
// codes, ALU operation codes, FSM state encoding and datapath mux selects.
// Optional feature macro: BNE_EN (bne decode, used in mc_controller).
package mc_pkg;

  localparam int MC_STATE_W = 4;

  // Primary opcodes, inst[31:26]
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // R-type funct codes, inst[5:0]
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Datapath mux selects
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH  = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b10;
  localparam logic [1:0] PCSRC_A      = 2'b11;
  localparam logic [1:0] REGDST_RT    = 2'b00;
  localparam logic [1:0] REGDST_RD    = 2'b01;
  localparam logic [1:0] REGDST_R31   = 2'b10;
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_PC       = 2'b10;

  // FSM states; encodings 14 and 15 are unused and fall back to fetch
  typedef enum logic [MC_STATE_W-1:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_I_EX    = 4'd8,
    S_I_WB    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13
  } state_t;

  // What the ALU is being asked to do in the current state
  typedef enum logic [2:0] {
    ACLS_NONE  = 3'd0,
    ACLS_ADD   = 3'd1,
    ACLS_SUB   = 3'd2,
    ACLS_FUNCT = 3'd3,
    ACLS_IMM   = 3'd4
  } alu_cls_t;

  // True for the R-type funct codes that go through R_EX/R_WB
  function automatic logic is_rtype_alu(input logic [5:0] fn);
    logic v;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: v = 1'b1;
      default:                               v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between mc_controller and the multicycle datapath/memory.
// master = controller side, slave = datapath side.
interface mc_controller_if;

  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero_out_alu;

  logic       zero_in_PC;
  logic       pc_write;
  logic       pc_write_cond;
  logic       IorD;
  logic       IRwrite;
  logic       alu_srcA;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] alu_srcB;
  logic [1:0] pc_src;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [2:0] alu_ctrl;
  logic       illegal_op;

  modport master (
    input  opcode, func, zero_out_alu,
    output zero_in_PC, pc_write, pc_write_cond, IorD, IRwrite, alu_srcA,
           reg_write, mem_read, mem_write, alu_srcB, pc_src, reg_dst,
           mem_to_reg, alu_ctrl, illegal_op
  );

  modport slave (
    output opcode, func, zero_out_alu,
    input  zero_in_PC, pc_write, pc_write_cond, IorD, IRwrite, alu_srcA,
           reg_write, mem_read, mem_write, alu_srcB, pc_src, reg_dst,
           mem_to_reg, alu_ctrl, illegal_op
  );

endinterface

// File: rtl/mc_controller_alu_dec.sv
// ALU operation decoder: the FSM names a class of ALU use for the current
// state, and this block turns it into a concrete alu_ctrl code.
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_cls_t   i_cls,
  input  logic [5:0] i_func,
  input  logic [5:0] i_opcode,
  output logic [2:0] o_alu_ctrl
);

  // Map ALU class plus instruction fields to an operation code
  always_comb begin
    o_alu_ctrl = ALU_AND;
    case (i_cls)
      ACLS_ADD: o_alu_ctrl = ALU_ADD;
      ACLS_SUB: o_alu_ctrl = ALU_SUB;
      ACLS_FUNCT: begin
        case (i_func)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
      ACLS_IMM: o_alu_ctrl = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default:  o_alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit. Moore FSM, one state per cycle, driving the
// datapath strobes and mux selects through mc_controller_if.master.
// Optional feature macro: BNE_EN -- when defined, bne (000101) is decoded
// as a branch taken on a non-zero ALU result; otherwise it is illegal.
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = MC_STATE_W
)(
  input  logic           clk,
  input  logic           rst,
  mc_controller_if.master mc
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic               w_illegal;

  logic       w_zero_in;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_irwrite;
  logic       w_alu_srca;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic [1:0] w_alu_srcb;
  logic [1:0] w_pc_src;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic [2:0] w_alu_ctrl;
  alu_cls_t   w_cls;

  // Next-state selection, including the ID decode and its illegal flag
  always_comb begin
    w_next_state = S_IF;
    w_illegal    = 1'b0;
    case (r_state)
      S_IF: w_next_state = S_ID;
      S_ID: begin
        case (mc.opcode)
          OP_LW, OP_SW: w_next_state = S_MEM_ADR;
          OP_RT: begin
            if (mc.func == FN_JR) begin
              w_next_state = S_JR;
            end else if (is_rtype_alu(mc.func)) begin
              w_next_state = S_R_EX;
            end else begin
              w_next_state = S_IF;
              w_illegal    = 1'b1;
            end
          end
          OP_BEQ: w_next_state = S_BRANCH;
`ifdef BNE_EN
          OP_BNE: w_next_state = S_BRANCH;
`endif
          OP_ADDI, OP_SLTI: w_next_state = S_I_EX;
          OP_J:             w_next_state = S_JUMP;
          OP_JAL:           w_next_state = S_JAL;
          default: begin
            w_next_state = S_IF;
            w_illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        if (mc.opcode == OP_LW) begin
          w_next_state = S_MEM_RD;
        end else if (mc.opcode == OP_SW) begin
          w_next_state = S_MEM_WR;
        end else begin
          w_next_state = S_IF;
        end
      end
      S_MEM_RD: w_next_state = S_MEM_WB;
      S_R_EX:   w_next_state = S_R_WB;
      S_I_EX:   w_next_state = S_I_WB;
      // Every final step, and any unused encoding, returns to fetch
      default:  w_next_state = S_IF;
    endcase
  end

  // State register: reset parks the FSM in fetch immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Moore output decode from the current state; anything unlisted is 0
  always_comb begin
    w_zero_in       = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_irwrite       = 1'b0;
    w_alu_srca      = SRCA_PC;
    w_reg_write     = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_alu_srcb      = SRCB_B;
    w_pc_src        = PCSRC_ALU;
    w_reg_dst       = REGDST_RT;
    w_mem_to_reg    = M2R_ALUOUT;
    w_cls           = ACLS_NONE;
    case (r_state)
      S_IF: begin
        w_mem_read = 1'b1;
        w_irwrite  = 1'b1;
        w_alu_srcb = SRCB_FOUR;
        w_cls      = ACLS_ADD;
        w_pc_write = 1'b1;
        w_pc_src   = PCSRC_ALU;
      end
      S_ID: begin
        w_alu_srcb = SRCB_IMM_SH;
        w_cls      = ACLS_ADD;
      end
      S_MEM_ADR: begin
        w_alu_srca = SRCA_A;
        w_alu_srcb = SRCB_IMM;
        w_cls      = ACLS_ADD;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = REGDST_RT;
        w_mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_R_EX: begin
        w_alu_srca = SRCA_A;
        w_alu_srcb = SRCB_B;
        w_cls      = ACLS_FUNCT;
      end
      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = REGDST_RD;
        w_mem_to_reg = M2R_ALUOUT;
      end
      S_I_EX: begin
        w_alu_srca = SRCA_A;
        w_alu_srcb = SRCB_IMM;
        w_cls      = ACLS_IMM;
      end
      S_I_WB: begin
        // ALU op kept stable so ALUOut is not disturbed during writeback
        w_reg_write  = 1'b1;
        w_reg_dst    = REGDST_RT;
        w_mem_to_reg = M2R_ALUOUT;
        w_cls        = ACLS_IMM;
      end
      S_BRANCH: begin
        w_alu_srca      = SRCA_A;
        w_alu_srcb      = SRCB_B;
        w_cls           = ACLS_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_src        = PCSRC_ALUOUT;
`ifdef BNE_EN
        w_zero_in       = (mc.opcode == OP_BNE) ? ~mc.zero_out_alu : mc.zero_out_alu;
`else
        w_zero_in       = mc.zero_out_alu;
`endif
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = PCSRC_JUMP;
      end
      S_JAL: begin
        // PC already holds PC+4; r31 and the jump target load on the same edge
        w_pc_write   = 1'b1;
        w_pc_src     = PCSRC_JUMP;
        w_reg_write  = 1'b1;
        w_reg_dst    = REGDST_R31;
        w_mem_to_reg = M2R_PC;
      end
      S_JR: begin
        w_pc_write = 1'b1;
        w_pc_src   = PCSRC_A;
      end
      default: begin
        w_cls = ACLS_NONE;
      end
    endcase
  end

  mc_alu_dec u_alu_dec (
    .i_cls      (w_cls),
    .i_func     (mc.func),
    .i_opcode   (mc.opcode),
    .o_alu_ctrl (w_alu_ctrl)
  );

  // While reset is held every strobe is forced low so nothing is written
  assign mc.zero_in_PC    = ~rst & w_zero_in;
  assign mc.pc_write      = ~rst & w_pc_write;
  assign mc.pc_write_cond = ~rst & w_pc_write_cond;
  assign mc.IorD          = ~rst & w_iord;
  assign mc.IRwrite       = ~rst & w_irwrite;
  assign mc.alu_srcA      = ~rst & w_alu_srca;
  assign mc.reg_write     = ~rst & w_reg_write;
  assign mc.mem_read      = ~rst & w_mem_read;
  assign mc.mem_write     = ~rst & w_mem_write;
  assign mc.illegal_op    = ~rst & w_illegal;
  assign mc.alu_srcB      = rst ? 2'b00  : w_alu_srcb;
  assign mc.pc_src        = rst ? 2'b00  : w_pc_src;
  assign mc.reg_dst       = rst ? 2'b00  : w_reg_dst;
  assign mc.mem_to_reg    = rst ? 2'b00  : w_mem_to_reg;
  assign mc.alu_ctrl      = rst ? 3'b000 : w_alu_ctrl;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit that drives the 32-bit multicycle datapath.
- Consumes the instruction register fields and the ALU zero flag.
- Produces every datapath and memory control strobe, sequenced by a Moore FSM (one state per cycle).
- Sits directly beside the datapath; the memory sees mem_read/mem_write from this block.

Parameters:
- STATE_W, 4, width of the state register.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  inst[31:26].
- func  in  6  inst[5:0].
- zero_out_alu  in  1  ALU zero flag from the datapath.
- zero_in_PC  out  1  branch-taken qualifier to the datapath PC enable.
- pc_write, pc_write_cond, IorD, IRwrite, alu_srcA, reg_write  out  1 each  datapath strobes.
- mem_read, mem_write  out  1 each  memory strobes.
- alu_srcB, pc_src, reg_dst, mem_to_reg  out  2 each  datapath mux selects.
- alu_ctrl  out  3  ALU operation.
- illegal_op  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- Mux encodings:
  - alu_srcA: 0=PC, 1=A.
  - alu_srcB: 00=B, 01=4, 10=sign-extended imm, 11=imm<<2.
  - pc_src: 00=ALU result, 01=jump address, 10=ALUOut, 11=A.
  - reg_dst: 00=rt, 01=rd, 10=r31.
  - mem_to_reg: 00=ALUOut, 01=MDR, 10=PC.
- alu_ctrl codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Reset: state=IF asynchronously. While rst=1, all outputs are forced to 0.
- Default: any output not listed for a state is 0.
- States and asserted outputs:
  - IF: mem_read, IorD=0, IRwrite, alu_srcA=0, alu_srcB=01, ADD, pc_write, pc_src=00. Next: ID.
  - ID: alu_srcA=0, alu_srcB=11, ADD (branch target into ALUOut). Next by opcode:
    - lw/sw -> MEM_ADR
    - R-type (000000): funct 001000 -> JR; funct add/sub/and/or/slt -> R_EX; other funct -> IF with illegal_op
    - beq (000100) -> BRANCH
    - addi (001000) / slti (001010) -> I_EX
    - j (000010) -> JUMP
    - jal (000011) -> JAL
    - other opcode -> IF with illegal_op
  - MEM_ADR: alu_srcA=1, alu_srcB=10, ADD. Next: MEM_RD for lw (100011), MEM_WR for sw (101011).
  - MEM_RD: mem_read, IorD=1. Next: MEM_WB.
  - MEM_WB: reg_write, reg_dst=00, mem_to_reg=01. Next: IF.
  - MEM_WR: mem_write, IorD=1. Next: IF.
  - R_EX: alu_srcA=1, alu_srcB=00, alu_ctrl from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT). Next: R_WB.
  - R_WB: reg_write, reg_dst=01, mem_to_reg=00. Next: IF.
  - I_EX: alu_srcA=1, alu_srcB=10, ADD for addi, SLT for slti. Next: I_WB.
  - I_WB: reg_write, reg_dst=00, mem_to_reg=00. alu_ctrl is held at the I_EX value. Next: IF.
  - BRANCH: alu_srcA=1, alu_srcB=00, SUB, pc_write_cond, pc_src=10, zero_in_PC=zero_out_alu. Next: IF.
  - JUMP: pc_write, pc_src=01. Next: IF.
  - JAL: pc_write, pc_src=01, reg_write, reg_dst=10, mem_to_reg=10. PC already holds PC+4 and is written to r31 at the same edge PC loads the target. Next: IF.
  - JR: pc_write, pc_src=11. Next: IF.
- Cycle counts (IF to the next IF):
  - lw 5
  - sw, R-type, addi, slti 4
  - beq, j, jal, jr 3
  - illegal 2
- zero_in_PC is 0 outside BRANCH.
- illegal_op is high only during ID when the decode fails.
- Reset mid-instruction: state returns to IF immediately, with no partial write after rst deasserts. Execution restarts with a fetch on the first clock edge after rst falls.
- Unused state encodings go to IF.

Optional Feature:
- BNE_EN
  - Defined: opcode 000101 (bne) decodes to BRANCH with zero_in_PC = ~zero_out_alu.
  - Undefined: bne is illegal (illegal_op pulse, return to IF).

Decomposition:
- Package mc_pkg holds:
  - opcode constants (OP_RT, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_J, OP_JAL)
  - funct constants
  - ALU_* codes
  - state enum/localparams (STATE_W wide)
  - mux select constants
- One sub-module: mc_alu_dec, combinational, maps (state class, func, opcode) to alu_ctrl.

Test Plan:
- rst=1 for 3 cycles, then released:
  - all outputs 0 during rst.
  - first cycle after release is IF: mem_read=1, IRwrite=1, pc_write=1, alu_srcB=01, alu_ctrl=010.
- opcode=000000, func=100010 (sub): state sequence IF, ID, R_EX (alu_ctrl=110), R_WB (reg_write=1, reg_dst=01), back to IF; 4 cycles.
- opcode=100011 (lw): 5 cycles; MEM_RD has IorD=1, mem_read=1; MEM_WB has reg_write=1, mem_to_reg=01.
- opcode=000100 (beq) with zero_out_alu=1: BRANCH has pc_write_cond=1, zero_in_PC=1, pc_src=10. Repeat with zero_out_alu=0: zero_in_PC=0.
- opcode=000011 (jal): JAL has reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=01. opcode=000000 with func=001000 (jr): pc_src=11.
- opcode=111111: illegal_op=1 for one cycle in ID, then IF. With BNE_EN, opcode=000101 and zero_out_alu=0 gives zero_in_PC=1.
- rst asserted during MEM_RD: state returns to IF immediately, and no reg_write ever occurs for that lw.
